// File: rtl/pipe_mem_wb_stage.sv
// Memory stage of the 5-stage pipeline: EX/MEM register, data memory, branch
// resolution and MEM/WB register driving the register-file write port.
module pipe_mem_wb_stage #(
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        EXwreg,
  input  logic        EXm2reg,
  input  logic        EXwmem,
  input  logic [4:0]  EXwn,
  input  logic [31:0] EXaluResult,
  input  logic [31:0] EXdi,
  input  logic [1:0]  EXjumpType,
  input  logic [31:0] EXjumpPc,
  input  logic        EXzero,
  output logic        MEMwreg,
  output logic        MEMm2reg,
  output logic [4:0]  MEMwn,
  output logic [31:0] MEMaluResult,
  output logic        MEMbranchTaken,
  output logic [31:0] MEMbranchPc,
  output logic        WBwreg,
  output logic [4:0]  WBwn,
  output logic [31:0] WBdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              memWmemReg;
  logic [31:0]       memDiReg;
  logic [1:0]        memJumpTypeReg;
  logic [31:0]       memJumpPcReg;
  logic              memZeroReg;

  logic              wbM2regReg;
  logic [31:0]       wbAluResultReg;
  logic [31:0]       wbMemDataReg;

  logic [31:0]       dataMem [DEPTH];
  logic [ADDR_W-1:0] memIndex;
  logic [31:0]       memData;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      MEMwreg        <= 1'b0;
      MEMm2reg       <= 1'b0;
      memWmemReg     <= 1'b0;
      MEMwn          <= 5'd0;
      MEMaluResult   <= 32'd0;
      memDiReg       <= 32'd0;
      memJumpTypeReg <= 2'b00;
      memJumpPcReg   <= 32'd0;
      memZeroReg     <= 1'b0;
    end else begin
      MEMwreg        <= EXwreg;
      MEMm2reg       <= EXm2reg;
      memWmemReg     <= EXwmem;
      MEMwn          <= EXwn;
      MEMaluResult   <= EXaluResult;
      memDiReg       <= EXdi;
      memJumpTypeReg <= EXjumpType;
      memJumpPcReg   <= EXjumpPc;
      memZeroReg     <= EXzero;
    end
  end

  always_comb begin
    MEMbranchTaken = 1'b0;
    unique case (memJumpTypeReg)
      2'b01:   MEMbranchTaken = memZeroReg;
      2'b10:   MEMbranchTaken = ~memZeroReg;
      2'b11:   MEMbranchTaken = 1'b1;
      default: MEMbranchTaken = 1'b0;
    endcase
  end

  assign MEMbranchPc = memJumpPcReg;

  // Word address only; byte offset and high bits are dropped so addresses wrap.
  assign memIndex = MEMaluResult[ADDR_W+1:2];
  assign memData  = dataMem[memIndex];

  // No reset on the array: contents survive clrn, only the write is gated.
  always_ff @(posedge clk) begin
    if (memWmemReg && clrn) begin
      dataMem[memIndex] <= memDiReg;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      WBwreg         <= 1'b0;
      wbM2regReg     <= 1'b0;
      WBwn           <= 5'd0;
      wbAluResultReg <= 32'd0;
      wbMemDataReg   <= 32'd0;
    end else begin
      WBwreg         <= MEMwreg;
      wbM2regReg     <= MEMm2reg;
      WBwn           <= MEMwn;
      wbAluResultReg <= MEMaluResult;
      wbMemDataReg   <= memData;
    end
  end

  assign WBdata = wbM2regReg ? wbMemDataReg : wbAluResultReg;

endmodule

// File: tb/tb_pipe_mem_wb_stage.sv
// Directed self-checking bench for pipe_mem_wb_stage: reset, ALU writeback,
// store/load with aliasing, branch resolution, reset during a store, streaming.
module tb_pipe_mem_wb_stage;

  logic        clk;
  logic        clrn;
  logic        EXwreg;
  logic        EXm2reg;
  logic        EXwmem;
  logic [4:0]  EXwn;
  logic [31:0] EXaluResult;
  logic [31:0] EXdi;
  logic [1:0]  EXjumpType;
  logic [31:0] EXjumpPc;
  logic        EXzero;
  logic        MEMwreg;
  logic        MEMm2reg;
  logic [4:0]  MEMwn;
  logic [31:0] MEMaluResult;
  logic        MEMbranchTaken;
  logic [31:0] MEMbranchPc;
  logic        WBwreg;
  logic [4:0]  WBwn;
  logic [31:0] WBdata;

  int checks = 0;
  int errors = 0;

  pipe_mem_wb_stage #(.ADDR_W(5)) dut (
    .clk(clk),
    .clrn(clrn),
    .EXwreg(EXwreg),
    .EXm2reg(EXm2reg),
    .EXwmem(EXwmem),
    .EXwn(EXwn),
    .EXaluResult(EXaluResult),
    .EXdi(EXdi),
    .EXjumpType(EXjumpType),
    .EXjumpPc(EXjumpPc),
    .EXzero(EXzero),
    .MEMwreg(MEMwreg),
    .MEMm2reg(MEMm2reg),
    .MEMwn(MEMwn),
    .MEMaluResult(MEMaluResult),
    .MEMbranchTaken(MEMbranchTaken),
    .MEMbranchPc(MEMbranchPc),
    .WBwreg(WBwreg),
    .WBwn(WBwn),
    .WBdata(WBdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, ".MEMwreg"},        32'(MEMwreg),        0);
    chk({tag, ".MEMm2reg"},       32'(MEMm2reg),       0);
    chk({tag, ".MEMwn"},          32'(MEMwn),          0);
    chk({tag, ".MEMaluResult"},   MEMaluResult,        0);
    chk({tag, ".MEMbranchTaken"}, 32'(MEMbranchTaken), 0);
    chk({tag, ".MEMbranchPc"},    MEMbranchPc,         0);
    chk({tag, ".WBwreg"},         32'(WBwreg),         0);
    chk({tag, ".WBwn"},           32'(WBwn),           0);
    chk({tag, ".WBdata"},         WBdata,              0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveIdle();
    EXwreg = 0; EXm2reg = 0; EXwmem = 0; EXwn = 0; EXaluResult = 0;
    EXdi = 0; EXjumpType = 0; EXjumpPc = 0; EXzero = 0;
  endtask

  task automatic driveRandom();
    EXwreg = 1'($urandom); EXm2reg = 1'($urandom); EXwmem = 1'($urandom);
    EXwn = 5'($urandom); EXaluResult = $urandom; EXdi = $urandom;
    EXjumpType = 2'($urandom); EXjumpPc = $urandom; EXzero = 1'($urandom);
  endtask

  task automatic driveAlu(input logic [4:0] wn, input logic [31:0] res);
    driveIdle();
    EXwreg = 1; EXwn = wn; EXaluResult = res;
  endtask

  task automatic driveStore(input logic [31:0] addr, input logic [31:0] data);
    driveIdle();
    EXwmem = 1; EXaluResult = addr; EXdi = data;
  endtask

  task automatic driveLoad(input logic [4:0] wn, input logic [31:0] addr);
    driveIdle();
    EXwreg = 1; EXm2reg = 1; EXwn = wn; EXaluResult = addr;
  endtask

  logic [1:0]  brJt   [7] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00};
  logic        brZero [7] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
  logic        brExp  [7] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
  logic [4:0]  bbWn   [4] = '{5'd10, 5'd11, 5'd12, 5'd13};
  logic [31:0] bbRes  [4] = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004};

  initial begin
    // Reset held with random EX activity
    clrn = 1'b0;
    driveRandom();
    #1;
    chkAllZero("rst_immediate");
    for (int i = 0; i < 3; i++) begin
      driveRandom();
      tick();
      chkAllZero($sformatf("rst_edge%0d", i));
    end
    driveIdle();
    clrn = 1'b1;

    // ALU writeback
    driveAlu(5, 32'h1234);
    tick();
    chk("alu.MEMaluResult", MEMaluResult, 32'h1234);
    chk("alu.MEMwn", 32'(MEMwn), 5);
    chk("alu.MEMwreg", 32'(MEMwreg), 1);
    chk("alu.WBwreg_before", 32'(WBwreg), 0);
    driveIdle();
    tick();
    chk("alu.WBwreg", 32'(WBwreg), 1);
    chk("alu.WBwn", 32'(WBwn), 5);
    chk("alu.WBdata", WBdata, 32'h1234);
    chk("alu.MEMwreg_after", 32'(MEMwreg), 0);

    // Store followed immediately by load of the same word
    driveStore(32'h8, 32'hDEAD_BEEF);
    tick();
    driveLoad(3, 32'h8);
    tick();
    chk("ld.MEMm2reg", 32'(MEMm2reg), 1);
    driveIdle();
    tick();
    chk("ld.WBdata", WBdata, 32'hDEAD_BEEF);
    chk("ld.WBwn", 32'(WBwn), 3);
    chk("ld.WBwreg", 32'(WBwreg), 1);

    // Aliased address 0x8+128
    driveLoad(4, 32'h88);
    tick();
    driveIdle();
    tick();
    chk("alias.WBdata", WBdata, 32'hDEAD_BEEF);

    // Byte offset ignored
    driveStore(32'hC, 32'h1122_3344);
    tick();
    driveLoad(6, 32'hF);
    tick();
    driveIdle();
    tick();
    chk("offset.WBdata", WBdata, 32'h1122_3344);

    // Branch resolution, target 0x40
    for (int i = 0; i < 7; i++) begin
      driveIdle();
      EXjumpType = brJt[i]; EXjumpPc = 32'h40; EXzero = brZero[i];
      tick();
      chk($sformatf("br%0d.taken", i), 32'(MEMbranchTaken), 32'(brExp[i]));
      chk($sformatf("br%0d.pc", i), MEMbranchPc, 32'h40);
    end

    // Reset between the capture edge and the write edge of a store
    driveStore(32'h8, 32'hCAFE_F00D);
    tick();
    #2;
    clrn = 1'b0;
    #1;
    chkAllZero("midrst");
    driveIdle();
    tick();
    clrn = 1'b1;
    driveLoad(7, 32'h8);
    tick();
    driveIdle();
    tick();
    chk("midrst.WBdata", WBdata, 32'hDEAD_BEEF);

    // Back-to-back ALU ops, no bubbles
    for (int i = 0; i < 5; i++) begin
      if (i < 4) driveAlu(bbWn[i], bbRes[i]);
      else driveIdle();
      tick();
      if (i < 4) begin
        chk($sformatf("bb%0d.MEMwn", i), 32'(MEMwn), 32'(bbWn[i]));
        chk($sformatf("bb%0d.MEMaluResult", i), MEMaluResult, bbRes[i]);
      end
      if (i >= 1) begin
        chk($sformatf("bb%0d.WBwreg", i - 1), 32'(WBwreg), 1);
        chk($sformatf("bb%0d.WBwn", i - 1), 32'(WBwn), 32'(bbWn[i - 1]));
        chk($sformatf("bb%0d.WBdata", i - 1), WBdata, bbRes[i - 1]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_mem_wb_stage.md
Name: pipe_mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register of the 5-stage CPU; sits directly downstream of the EX stage.
- Captures EX results on the EX/MEM register, performs the data-memory load/store and resolves branches/jumps.
- Produces MEMaluResult and WBdata, which EX uses as forwarding sources.
- Registers the result into WB and drives the register-file write port.

Parameters:
- ADDR_W, 5, log2 of data-memory depth in 32-bit words (default 32 words).

Ports:
- clk  input  1  rising-edge clock
- clrn  input  1  asynchronous active-low reset
- EXwreg  input  1  EX: register write enable
- EXm2reg  input  1  EX: writeback selects memory data
- EXwmem  input  1  EX: memory write enable
- EXwn  input  5  EX: destination register number
- EXaluResult  input  32  EX: ALU result / memory byte address
- EXdi  input  32  EX: store data, already forwarded
- EXjumpType  input  2  EX: 00 none, 01 beq, 10 bne, 11 unconditional
- EXjumpPc  input  32  EX: branch/jump target
- EXzero  input  1  EX: ALU zero flag
- MEMwreg  output  1  MEM: register write enable, for hazard logic
- MEMm2reg  output  1  MEM: load in MEM, for load-use detection
- MEMwn  output  5  MEM: destination register
- MEMaluResult  output  32  MEM: ALU result, forwarding source
- MEMbranchTaken  output  1  MEM: redirect PC and flush IF/ID/EX
- MEMbranchPc  output  32  MEM: redirect target
- WBwreg  output  1  WB: register-file write enable
- WBwn  output  5  WB: register-file write address
- WBdata  output  32  WB: write data, forwarding source

Behaviour:
- Single clock clk. Reset clrn is asynchronous, active-low, and clears every pipeline register immediately, independent of clk.
- EX/MEM register:
  - On posedge clk it captures all EX* inputs into MEM-side registers.
  - Reset values: wreg, m2reg, wmem, wn, jumpType, zero all 0; aluResult, di, jumpPc all 0.
- MEMwreg, MEMm2reg, MEMwn and MEMaluResult are direct register outputs. Latency is 1 cycle from EX inputs.
- Branch resolution (combinational from MEM registers):
  - MEMbranchTaken = (jt==01 & zero) | (jt==10 & ~zero) | (jt==11).
  - MEMbranchPc = registered jumpPc.
  - jt==00 gives taken=0.
  - After reset, taken=0 and pc=0.
- Data memory:
  - 2^ADDR_W x 32 array.
  - Word index = aluResult[ADDR_W+1:2]. Bits [1:0] and bits above ADDR_W+1 are ignored, so addresses alias/wrap.
  - Read is asynchronous: memData = mem[index].
  - Write is synchronous: on posedge clk, when MEM wmem==1 and clrn==1, mem[index] <= di.
  - No write while clrn==0.
  - Array contents are not cleared by reset.
- Store followed by load to the same word in the next instruction: the store is written at the edge ending its MEM cycle, so the load reads the new value. No bypass is needed.
- MEM/WB register:
  - On posedge clk it captures MEM wreg, m2reg, wn, aluResult and memData.
  - Reset values are all 0.
- WBwreg and WBwn are register outputs.
- WBdata = WBm2reg ? WBmemData : WBaluResult. Reset value is 0.
- End-to-end latency from EX inputs to WBdata is 2 clocks.
- Flushing younger instructions is the upstream stages' responsibility. This stage never squashes its own contents on MEMbranchTaken.
- The stage has no stall input and advances every cycle.
- Reset asserted mid-operation: all outputs go to reset values within the same cycle, an in-flight store is dropped, and memory keeps its prior contents.

Test Plan:
- Reset: drive clrn=0 with random EX inputs -> all outputs 0 immediately and through 3 clock edges. Release reset -> outputs follow inputs after 1 (MEM) or 2 (WB) edges.
- ALU writeback: EXwreg=1, EXm2reg=0, EXwn=5, EXaluResult=0x1234 -> next cycle MEMaluResult=0x1234, MEMwn=5. Following cycle WBwreg=1, WBwn=5, WBdata=0x1234.
- Store then load:
  - Store EXwmem=1, EXaluResult=0x8, EXdi=0xDEADBEEF.
  - Next instruction is a load: EXm2reg=1, EXwreg=1, EXaluResult=0x8, EXwn=3.
  - Expect WBdata=0xDEADBEEF two cycles after the load is presented.
  - Repeating with address 0x8+128 (ADDR_W=5) aliases and returns the same value.
- Branches with EXjumpPc=0x40:
  - jt=01, zero=1 -> MEMbranchTaken=1, MEMbranchPc=0x40.
  - jt=01, zero=0 -> 0.
  - jt=10, zero=0 -> 1.
  - jt=11 -> 1 regardless of zero.
  - jt=00 -> 0.
- Reset mid-store: present a store, then assert clrn low before the capturing edge is followed by the write edge -> memory word unchanged on later load. WBdata returns the old value.
- Back-to-back: 4 consecutive ALU ops with distinct wn/results -> each appears on MEM outputs 1 cycle and on WB outputs 2 cycles after entry, in order, with no bubbles.
